// File: rtl/reset_combine_pkg.sv
// rtl/reset_combine_pkg.sv - FSM state codes, clog2 and parameter legality for reset_combine_seq
package reset_combine_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_SYNC    = 2'd0;
    localparam state_t ST_STRETCH = 2'd1;
    localparam state_t ST_SEQ     = 2'd2;
    localparam state_t ST_RUN     = 2'd3;

    // Never returns less than 1 so that every derived vector has at least one bit.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) begin
            width++;
        end
        return width;
    endfunction

    function automatic bit params_legal(input int num_src, input int sync_stages,
                                        input int stretch, input int num_out,
                                        input int out_gap);
        return (num_src >= 1) && (sync_stages >= 2) && (stretch >= 0) &&
               (num_out >= 1) && (out_gap >= 1);
    endfunction

endpackage

// File: rtl/reset_sync_chain.sv
// rtl/reset_sync_chain.sv - async-assert / sync-release flop chain with D tied high
module reset_sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic clr_n,
    output logic sync,
    output logic sync_early
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], 1'b1};
        end
    end

    // sync_early leads sync by one edge so a consumer can act on the edge sync rises.
    assign sync       = chain_q[STAGES-1];
    assign sync_early = chain_q[STAGES-2];

endmodule

// File: rtl/reset_combine_seq.sv
// rtl/reset_combine_seq.sv - reset combiner and ordered release sequencer; optional RESET_COMBINE_CAUSE_EN
module reset_combine_seq
    import reset_combine_pkg::*;
#(
    parameter int                 NUM_SRC     = 2,
    parameter logic [NUM_SRC-1:0] SRC_MASK    = '1,
    parameter int                 SYNC_STAGES = 2,
    parameter int                 STRETCH     = 4,
    parameter int                 NUM_OUT     = 1,
    parameter int                 OUT_GAP     = 1
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [NUM_SRC-1:0] RST_IN,
    output logic [NUM_OUT-1:0] RST_OUT,
    output logic               IN_RESET,
    output logic [NUM_SRC-1:0] CAUSE,
    input  logic               CAUSE_CLR
);

    localparam int CNT_MAX = (STRETCH > OUT_GAP) ? STRETCH : OUT_GAP;
    localparam int CNT_W   = clog2(CNT_MAX + 1);
    localparam int STG_W   = clog2(NUM_OUT + 1);

    localparam logic [CNT_W-1:0] STRETCH_LOAD = CNT_W'((STRETCH > 0) ? STRETCH - 1 : 0);
    localparam logic [CNT_W-1:0] GAP_LOAD     = CNT_W'(OUT_GAP - 1);
    localparam logic [STG_W-1:0] LAST_STAGE   = STG_W'(NUM_OUT - 1);

    generate
        if (!params_legal(NUM_SRC, SYNC_STAGES, STRETCH, NUM_OUT, OUT_GAP)) begin : g_param_error
            $error("reset_combine_seq: illegal parameter set");
        end
    endgenerate

    logic               comb_n;
    logic               sync;
    logic               sync_early;
    logic               sync_rise;
    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [STG_W-1:0]   stage_q;
    logic [NUM_OUT-1:0] rel_q;
    logic               do_release;

    // AND-only combination: a masked source can never pull the internal reset low.
    assign comb_n = RST_N & (&(RST_IN | ~SRC_MASK));

    reset_sync_chain #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk       (CLK),
        .clr_n     (comb_n),
        .sync      (sync),
        .sync_early(sync_early)
    );

    assign sync_rise = sync_early & ~sync;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        do_release = 1'b0;
        case (state_q)
            ST_SYNC: begin
                if (sync_rise) begin
                    if (STRETCH > 0) begin
                        state_d = ST_STRETCH;
                        cnt_d   = STRETCH_LOAD;
                    end else begin
                        do_release = 1'b1;
                    end
                end
            end
            ST_STRETCH, ST_SEQ: begin
                if (cnt_q == '0) begin
                    do_release = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_SYNC;
            end
        endcase
        if (do_release) begin
            cnt_d   = GAP_LOAD;
            state_d = (stage_q == LAST_STAGE) ? ST_RUN : ST_SEQ;
        end
    end

    // Outputs are a registered thermometer so each release edge flips exactly one bit.
    always_ff @(posedge CLK or negedge comb_n) begin
        if (!comb_n) begin
            state_q <= ST_SYNC;
            cnt_q   <= '0;
            stage_q <= '0;
            rel_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (do_release) begin
                stage_q <= stage_q + 1'b1;
                rel_q   <= (rel_q << 1) | NUM_OUT'(1);
            end
        end
    end

    assign RST_OUT  = rel_q;
    assign IN_RESET = ~(&rel_q);

`ifdef RESET_COMBINE_CAUSE_EN
    logic [NUM_SRC-1:0] src_meta_q;
    logic [NUM_SRC-1:0] src_sync_q;
    logic [NUM_SRC-1:0] cause_q;

    // Cleared only by the block reset so flags survive resets requested through RST_IN.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            src_meta_q <= '1;
            src_sync_q <= '1;
            cause_q    <= '0;
        end else begin
            src_meta_q <= RST_IN | ~SRC_MASK;
            src_sync_q <= src_meta_q;
            cause_q    <= (~src_sync_q & SRC_MASK) | (cause_q & {NUM_SRC{~CAUSE_CLR}});
        end
    end

    assign CAUSE = cause_q;
`else
    logic unused_cause_clr;
    assign unused_cause_clr = CAUSE_CLR;
    assign CAUSE            = '0;
`endif

endmodule

// File: tb/tb_reset_combine_seq.sv
// tb/tb_reset_combine_seq.sv - randomized self-checking bench for reset_combine_seq
module tb_reset_combine_seq;

`ifdef RESET_COMBINE_CAUSE_EN
    localparam bit CAUSE_ON = 1'b1;
`else
    localparam bit CAUSE_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [1:0] src_a, src_b, src_c;
    logic       clr_a, clr_b, clr_c;
    logic [2:0] out_a, out_c;
    logic [0:0] out_b;
    logic       inr_a, inr_b, inr_c;
    logic [1:0] cause_a, cause_b, cause_c;

    reset_combine_seq #(.NUM_SRC(2), .SRC_MASK(2'b11), .SYNC_STAGES(2), .STRETCH(4),
                        .NUM_OUT(3), .OUT_GAP(2)) dut_a (
        .CLK(clk), .RST_N(rst_n), .RST_IN(src_a), .RST_OUT(out_a),
        .IN_RESET(inr_a), .CAUSE(cause_a), .CAUSE_CLR(clr_a));

    reset_combine_seq #(.NUM_SRC(2), .SRC_MASK(2'b11), .SYNC_STAGES(2), .STRETCH(0),
                        .NUM_OUT(1), .OUT_GAP(1)) dut_b (
        .CLK(clk), .RST_N(rst_n), .RST_IN(src_b), .RST_OUT(out_b),
        .IN_RESET(inr_b), .CAUSE(cause_b), .CAUSE_CLR(clr_b));

    reset_combine_seq #(.NUM_SRC(2), .SRC_MASK(2'b01), .SYNC_STAGES(2), .STRETCH(4),
                        .NUM_OUT(3), .OUT_GAP(2)) dut_c (
        .CLK(clk), .RST_N(rst_n), .RST_IN(src_c), .RST_OUT(out_c),
        .IN_RESET(inr_c), .CAUSE(cause_c), .CAUSE_CLR(clr_c));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: count edges since the combined reset last rose, then apply the release formula.
    wire m_comb_a = rst_n & src_a[0] & src_a[1];
    wire m_comb_b = rst_n & src_b[0] & src_b[1];
    wire m_comb_c = rst_n & src_c[0];
    int e_a = 0, e_b = 0, e_c = 0;

    always @(posedge clk) begin
        if (m_comb_a) e_a++;
        if (m_comb_b) e_b++;
        if (m_comb_c) e_c++;
    end
    always @(m_comb_a) if (!m_comb_a) e_a = 0;
    always @(m_comb_b) if (!m_comb_b) e_b = 0;
    always @(m_comb_c) if (!m_comb_c) e_c = 0;

    function automatic int exp_cnt(input int e, input int st, input int n_out, input int gap);
        int n;
        if (e < 2 + st) return 0;
        n = (e - 2 - st) / gap + 1;
        return (n > n_out) ? n_out : n;
    endfunction

    function automatic logic [31:0] therm(input int n);
        return (32'd1 << n) - 32'd1;
    endfunction

    function automatic logic is_thermo(input logic [31:0] v);
        return ((v + 32'd1) & v) == 32'd0;
    endfunction

    // Hand-computed release table for STRETCH=4, NUM_OUT=3, OUT_GAP=2.
    function automatic logic [31:0] lit_seq(input int ed);
        if (ed < 6) return 32'd0;
        if (ed < 8) return 32'd1;
        if (ed < 10) return 32'd3;
        return 32'd7;
    endfunction

    bit check_en = 1'b0;

    always @(negedge clk) begin
        if (check_en) begin
            chk("a_out", out_a, therm(exp_cnt(e_a, 4, 3, 2)));
            chk("a_inr", inr_a, exp_cnt(e_a, 4, 3, 2) < 3);
            chk("a_thermo", is_thermo(out_a), 1);
            chk("b_out", out_b, therm(exp_cnt(e_b, 0, 1, 1)));
            chk("b_inr", inr_b, exp_cnt(e_b, 0, 1, 1) < 1);
            chk("c_out", out_c, therm(exp_cnt(e_c, 4, 3, 2)));
            chk("c_inr", inr_c, exp_cnt(e_c, 4, 3, 2) < 3);
            chk("c_thermo", is_thermo(out_c), 1);
            chk("c_cause_masked", cause_c[1], 0);
`ifndef RESET_COMBINE_CAUSE_EN
            chk("cause_tied", {cause_a, cause_b, cause_c}, 0);
`endif
        end
    end

    logic [1:0] hold [3];
    int         left [3][2];
    int         rst_left;

    initial begin
        rst_n = 1'b0;
        src_a = 2'b11; src_b = 2'b11; src_c = 2'b01;
        clr_a = 1'b0;  clr_b = 1'b0;  clr_c = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_a", out_a, 0);
        chk("rst_inr_a", inr_a, 1);
        chk("rst_out_b", out_b, 0);
        chk("rst_out_c", out_c, 0);
        chk("rst_cause_a", cause_a, 0);
        check_en = 1'b1;

        // Release the block reset; dut_c has its masked source held low throughout.
        #1 rst_n = 1'b1;
        for (int ed = 1; ed <= 12; ed++) begin
            @(posedge clk); #1;
            chk("t1_a", out_a, lit_seq(ed));
            chk("t1_inr_a", inr_a, ed < 10);
            chk("t1_b", out_b, ed >= 2);
            chk("t3_c_masked_release", out_c, lit_seq(ed));
        end

        // Sub-cycle glitch between edges.
        @(posedge clk); #1 src_a[1] = 1'b0;
        #1;
        chk("t2_async_out", out_a, 0);
        chk("t2_async_inr", inr_a, 1);
        #2 src_a[1] = 1'b1;
        for (int ed = 1; ed <= 10; ed++) begin
            @(posedge clk); #1;
            chk("t2_resequence", out_a, lit_seq(ed));
        end

        // Enabled source on the masked instance resets it.
        @(posedge clk); #2 src_c[0] = 1'b0;
        #1 chk("t3_c_async", out_c, 0);
        repeat (4) @(posedge clk);
        #2 src_c[0] = 1'b1;
        for (int ed = 1; ed <= 10; ed++) begin
            @(posedge clk); #1;
            chk("t3_c_release", out_c, lit_seq(ed));
        end

        // Re-assert between RST_OUT[0] and RST_OUT[1].
        @(posedge clk); #2 src_a[0] = 1'b0;
        @(posedge clk); #2 src_a[0] = 1'b1;
        for (int ed = 1; ed <= 7; ed++) begin
            @(posedge clk); #1;
            chk("t4_pre", out_a, lit_seq(ed));
        end
        #1 src_a[0] = 1'b0;
        #1;
        chk("t4_drop", out_a, 0);
        chk("t4_drop_inr", inr_a, 1);
        #1 src_a[0] = 1'b1;
        for (int ed = 1; ed <= 10; ed++) begin
            @(posedge clk); #1;
            chk("t4_restart", out_a, lit_seq(ed));
        end

        // Cause capture, persistence, clear, and set-beats-clear.
        @(posedge clk); #2 clr_a = 1'b1; clr_c = 1'b1;
        @(posedge clk); #2 clr_a = 1'b0; clr_c = 1'b0;
        #1 chk("t6_cleared", cause_a, 0);
        @(posedge clk); #2 src_a[0] = 1'b0;
        repeat (4) @(posedge clk);
        #2 src_a[0] = 1'b1;
        repeat (4) @(posedge clk);
        #1 chk("t6_capture", cause_a, CAUSE_ON ? 32'd1 : 32'd0);
        repeat (12) @(posedge clk);
        #1 chk("t6_persist", cause_a, CAUSE_ON ? 32'd1 : 32'd0);
        #1 clr_a = 1'b1;
        @(posedge clk); #2 clr_a = 1'b0;
        #1 chk("t6_clear", cause_a, 0);
        @(posedge clk); #2 src_a[0] = 1'b0;
        repeat (4) @(posedge clk);
        #2 src_a[0] = 1'b1;
        @(posedge clk); #2 clr_a = 1'b1;
        @(posedge clk); #1 chk("t6_set_wins", cause_a, CAUSE_ON ? 32'd1 : 32'd0);
        #1 clr_a = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("t6_set_kept", cause_a, CAUSE_ON ? 32'd1 : 32'd0);

        // Randomized sources, block reset and glitches against the reference.
        for (int d = 0; d < 3; d++) begin
            hold[d] = 2'b11;
            for (int i = 0; i < 2; i++) left[d][i] = 0;
        end
        rst_left = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk); #2;
            for (int d = 0; d < 3; d++) begin
                for (int i = 0; i < 2; i++) begin
                    if (left[d][i] > 0) left[d][i]--;
                    else if ($urandom_range(0, 149) == 0) left[d][i] = $urandom_range(1, 8);
                    hold[d][i] = (left[d][i] == 0);
                end
            end
            if (rst_left > 0) rst_left--;
            else if ($urandom_range(0, 399) == 0) rst_left = $urandom_range(1, 3);
            rst_n = (rst_left == 0);
            src_a = hold[0]; src_b = hold[1]; src_c = hold[2];
            if ($urandom_range(0, 49) == 0) begin
                case ($urandom_range(0, 2))
                    0: src_a[$urandom_range(0, 1)] = 1'b0;
                    1: src_b[$urandom_range(0, 1)] = 1'b0;
                    default: src_c[$urandom_range(0, 1)] = 1'b0;
                endcase
                #2;
                src_a = hold[0]; src_b = hold[1]; src_c = hold[2];
            end
        end

        @(posedge clk); #2;
        rst_n = 1'b1; src_a = 2'b11; src_b = 2'b11; src_c = 2'b11;
        repeat (20) @(posedge clk);
        #1;
        chk("final_a", out_a, 7);
        chk("final_b", out_b, 1);
        chk("final_c", out_c, 7);
        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
